// File: rtl/pnu_univ_shift_reg.sv
// pnu_univ_shift_reg
//   Parametrised universal shift register: hold, shift right, shift left and
//   parallel load, gated by a clock enable. A frame counter tracks consecutive
//   same-direction shifts. Each WIDTH-th shift pulses FRAME_DONE and captures
//   the completed word in FRAME. Use it as a serial-to-parallel or
//   parallel-to-serial converter.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   EN         clock enable; 0 holds all state, FRAME_DONE reads 0
//   MODE       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   Din        serial in for right shifts (enters Q[WIDTH-1])
//   Din_L      serial in for left shifts (enters Q[0])
//   PIN        parallel load data
//   Q          register contents
//   SO_R/SO_L  serial outs, Q[0] / Q[WIDTH-1]
//   CNT        consecutive same-direction shifts in the current frame
//   FRAME_DONE one-cycle pulse after the edge that completes a frame
//   FRAME      post-shift Q captured at the last frame completion
module pnu_univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             Din,
    input  logic             Din_L,
    input  logic [WIDTH-1:0] PIN,
    output logic [WIDTH-1:0] Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic [CNT_W-1:0] CNT,
    output logic             FRAME_DONE,
    output logic [WIDTH-1:0] FRAME
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Direction of the shift run in progress: 0 = right, 1 = left.
    logic             dir_q;

    logic [WIDTH-1:0] q_nxt;
    logic             shift;
    logic             dir_nxt;
    logic             same_dir;
    logic [CNT_W-1:0] cnt_inc;
    logic             frame_hit;

    always_comb begin
        q_nxt   = Q;
        shift   = 1'b0;
        dir_nxt = dir_q;
        case (MODE)
            MODE_RIGHT: begin
                q_nxt   = {Din, Q[WIDTH-1:1]};
                shift   = 1'b1;
                dir_nxt = 1'b0;
            end
            MODE_LEFT: begin
                q_nxt   = {Q[WIDTH-2:0], Din_L};
                shift   = 1'b1;
                dir_nxt = 1'b1;
            end
            MODE_LOAD: q_nxt = PIN;
            default:   q_nxt = Q;
        endcase
        same_dir  = (dir_nxt == dir_q);
        cnt_inc   = CNT + CNT_ONE;
        // A direction change restarts the count at 1. WIDTH >= 2, so a
        // direction change can never complete a frame.
        frame_hit = shift && same_dir && (cnt_inc == CNT_FULL);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q          <= '0;
            CNT        <= '0;
            FRAME_DONE <= 1'b0;
            FRAME      <= '0;
            dir_q      <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            if (EN) begin
                Q <= q_nxt;
                if (MODE == MODE_LOAD) begin
                    CNT <= '0;
                end else if (shift) begin
                    if (!same_dir) begin
                        CNT   <= CNT_ONE;
                        dir_q <= dir_nxt;
                    end else if (frame_hit) begin
                        CNT        <= '0;
                        FRAME_DONE <= 1'b1;
                        FRAME      <= q_nxt;
                    end else begin
                        CNT <= cnt_inc;
                    end
                end
            end
        end
    end

    assign SO_R = Q[0];
    assign SO_L = Q[WIDTH-1];

endmodule
